tristate_bus_arbiter: RTL



---
 rtl/tristate_bus_arbiter_pkg.sv | 34 +++
 rtl/tristate_bus_arbiter_rr_priority_picker.sv | 48 ++++
 rtl/tristate_bus_arbiter.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/tristate_bus_arbiter_pkg.sv
// Shared definitions for tristate_bus_arbiter.
// Contents:
//   arb_state_e           - FSM state encoding (idle / drive / turnaround)
//   clog2()               - ceiling log2 for parameter-derived widths
//   TBA_CHECK_RANGE       - elaboration-time parameter range check
`ifndef TRISTATE_BUS_ARBITER_PKG_SV
`define TRISTATE_BUS_ARBITER_PKG_SV

// Expands to a generate-if that stops elaboration when val is outside [lo, hi].
`define TBA_CHECK_RANGE(val, lo, hi, msg) \
  if ((int'(val) < (lo)) || (int'(val) > (hi))) begin \
    $error(msg); \
  end

package tristate_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StDrive = 2'd1,
    StTurn  = 2'd2
  } arb_state_e;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    while ((64'd1 << res) < 64'(value)) begin
      res++;
    end
    return res;
  endfunction

endpackage

`endif

// File: rtl/tristate_bus_arbiter_rr_priority_picker.sv
// Round-robin priority picker (purely combinational).
// Finds the first set bit of req searching upward from ptr, wrapping at N_REQ.
// Ports:
//   req      - request vector
//   ptr      - index with highest priority
//   pick     - one-hot selection (zero when nothing requested)
//   pick_idx - index of the selection (zero when nothing requested)
//   any      - at least one request present
module tristate_bus_arbiter_rr_priority_picker
  import tristate_bus_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  localparam int unsigned IdxW = clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IdxW-1:0]  ptr,
  output logic [N_REQ-1:0] pick,
  output logic [IdxW-1:0]  pick_idx,
  output logic             any
);

  logic [N_REQ-1:0] rot;
  logic [IdxW:0]    sum;

  always_comb begin
    // rot[i] corresponds to requester (ptr + i) mod N_REQ
    rot      = N_REQ'({req, req} >> ptr);
    pick     = '0;
    pick_idx = '0;
    any      = 1'b0;
    sum      = '0;
    // Walk downward so the lowest rotated position wins
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        any = 1'b1;
        sum = {1'b0, ptr} + (IdxW + 1)'(i);
      end
    end
    if (sum >= (IdxW + 1)'(N_REQ)) begin
      sum = sum - (IdxW + 1)'(N_REQ);
    end
    pick_idx = sum[IdxW-1:0];
    if (any) begin
      pick[pick_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/tristate_bus_arbiter.sv
// Round-robin owner arbitration for one shared tri-state net.
// Generates per-requester buffer disables from flops and inserts TURN_CYC
// all-high-Z cycles between ownerships so two drivers never overlap.
// Ports:
//   clk   - clock, rising edge
//   rst_n - asynchronous active-low reset
//   req   - per-requester level request
//   gnt   - one-hot ownership grant, zero when no owner
//   ctl   - per-requester buffer disable (1 = high-Z), always ~gnt
//   owner - index of current owner, zero when not busy
//   busy  - high while an owner drives the net
module tristate_bus_arbiter
  import tristate_bus_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned TURN_CYC = 1,
  parameter int unsigned MAX_HOLD = 16,
  localparam int unsigned IdxW    = clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [N_REQ-1:0] ctl,
  output logic [IdxW-1:0]  owner,
  output logic             busy
);

  localparam int unsigned HoldRaw = clog2(MAX_HOLD + 1);
  localparam int unsigned HoldW   = (HoldRaw < 1) ? 1 : HoldRaw;
  localparam logic [HoldW-1:0] HoldMax = '1;

  `TBA_CHECK_RANGE(N_REQ, 2, 8, "N_REQ must be within 2..8")
  `TBA_CHECK_RANGE(TURN_CYC, 1, 15, "TURN_CYC must be within 1..15")
  `TBA_CHECK_RANGE(MAX_HOLD, 0, 255, "MAX_HOLD must be within 0..255")

  arb_state_e       state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [N_REQ-1:0] ctl_q, ctl_d;
  logic [IdxW-1:0]  owner_q, owner_d;
  logic [IdxW-1:0]  ptr_q, ptr_d;
  logic             busy_q, busy_d;
  logic [HoldW-1:0] hold_q, hold_d;
  logic [3:0]       turn_q, turn_d;

  logic [N_REQ-1:0] pick;
  logic [IdxW-1:0]  pick_idx;
  logic             pick_any;
  logic             owner_req, other_req, limit_hit;

  tristate_bus_arbiter_rr_priority_picker #(
    .N_REQ (N_REQ)
  ) u_picker (
    .req      (req),
    .ptr      (ptr_q),
    .pick     (pick),
    .pick_idx (pick_idx),
    .any      (pick_any)
  );

  always_comb begin
    owner_req = |(req & gnt_q);
    other_req = |(req & ~gnt_q);
    // hold_q counts completed drive cycles; this cycle is number hold_q + 1
    limit_hit = (MAX_HOLD != 0) && ((32'(hold_q) + 32'd1) == MAX_HOLD);
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ctl_d   = ctl_q;
    owner_d = owner_q;
    busy_d  = busy_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    turn_d  = turn_q;
    case (state_q)
      StIdle: begin
        if (pick_any) begin
          state_d = StDrive;
          gnt_d   = pick;
          ctl_d   = ~pick;
          owner_d = pick_idx;
          busy_d  = 1'b1;
          hold_d  = '0;
        end
      end
      StDrive: begin
        if (!owner_req || (limit_hit && other_req)) begin
          state_d = StTurn;
          gnt_d   = '0;
          ctl_d   = '1;
          owner_d = '0;
          busy_d  = 1'b0;
          ptr_d   = (owner_q == IdxW'(N_REQ - 1)) ? '0 : owner_q + IdxW'(1);
          turn_d  = 4'(TURN_CYC - 1);
        end else if (limit_hit) begin
          // Nobody else waiting: keep the bus and open a fresh hold window
          hold_d = '0;
        end else if (hold_q != HoldMax) begin
          hold_d = hold_q + HoldW'(1);
        end
      end
      StTurn: begin
        if (turn_q != 4'd0) begin
          turn_d = turn_q - 4'd1;
        end else if (pick_any) begin
          state_d = StDrive;
          gnt_d   = pick;
          ctl_d   = ~pick;
          owner_d = pick_idx;
          busy_d  = 1'b1;
          hold_d  = '0;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      gnt_q   <= '0;
      ctl_q   <= '1;
      owner_q <= '0;
      ptr_q   <= '0;
      busy_q  <= 1'b0;
      hold_q  <= '0;
      turn_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ctl_q   <= ctl_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      busy_q  <= busy_d;
      hold_q  <= hold_d;
      turn_q  <= turn_d;
    end
  end

  assign gnt   = gnt_q;
  assign ctl   = ctl_q;
  assign owner = owner_q;
  assign busy  = busy_q;

`ifndef SYNTHESIS
  // Length of the current run of no-owner cycles, saturating
  logic [3:0] hz_run_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hz_run_q <= 4'hf;
    end else if (gnt_q != '0) begin
      hz_run_q <= '0;
    end else if (hz_run_q != 4'hf) begin
      hz_run_q <= hz_run_q + 4'd1;
    end
  end

  a_single_driver: assert property (@(posedge clk) disable iff (!rst_n)
    $countones(~ctl_q) <= 1);
  a_ctl_is_not_gnt: assert property (@(posedge clk) disable iff (!rst_n)
    ctl_q == ~gnt_q);
  a_turn_gap: assert property (@(posedge clk) disable iff (!rst_n)
    (gnt_q != '0 && hz_run_q != '0) |-> hz_run_q >= 4'(TURN_CYC));
  a_no_direct_swap: assert property (@(posedge clk) disable iff (!rst_n)
    (gnt_q != '0 && $past(gnt_q) != '0) |-> gnt_q == $past(gnt_q));
`endif

endmodule
